// File: rtl/photo_pulse_scheduler.sv
// photo_pulse_scheduler: periodic calibration-pulse scheduler driving the photo selector TRIG
// Ports: CLK/RESET (sync, active-high); DIN with WR_PERIOD/WR_CTRL strobes program period and
// run/abort/burst; BUSY_IN holds off a due trigger; TRIG_OUT is the registered trigger;
// DO = {2'b0, done, running, state[3:0], deferrals[7:0], pulses[15:0]}.
module photo_pulse_scheduler #(
   parameter int PERIOD_W = 24,
   parameter int TRIG_W   = 4,
   parameter int CNT_W    = 16
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] DIN,
   input  logic        WR_PERIOD,
   input  logic        WR_CTRL,
   input  logic [2:0]  BUSY_IN,
   output logic        TRIG_OUT,
   output logic [31:0] DO
);
   localparam int TCW = (TRIG_W > 1) ? $clog2(TRIG_W) : 1;
   typedef enum logic [3:0] {S_IDLE = 4'b0001, S_WAIT = 4'b0010, S_HOLD = 4'b0100, S_FIRE = 4'b1000} state_t;
   state_t              r_state;
   state_t              w_next;
   logic [PERIOD_W-1:0] r_period;
   logic [PERIOD_W-1:0] r_cnt;
   logic [CNT_W-1:0]    r_burst;
   logic [CNT_W-1:0]    r_pulses;
   logic [7:0]          r_defer;
   logic [TCW-1:0]      r_tcnt;
   logic                r_running;
   logic                r_done;
   logic                r_trig;
   logic                r_quit;
   logic                w_start;
   logic                w_quit;
   logic                w_last;
   logic                w_bend;
   logic [PERIOD_W-1:0] w_per;
   logic [PERIOD_W-1:0] w_reload;
   assign w_start  = WR_CTRL && DIN[0] && !DIN[1];
   assign w_quit   = WR_CTRL && (DIN[1] || !DIN[0]);
   assign w_last   = r_tcnt == TCW'(TRIG_W - 1);
   assign w_bend   = (r_burst != '0) && (r_pulses == r_burst);
   // a period written in the same cycle as a reload is the one that reload uses
   assign w_per    = WR_PERIOD ? DIN[PERIOD_W-1:0] : r_period;
   assign w_reload = (w_per == '0) ? '0 : w_per - PERIOD_W'(1);
   always_comb begin
      w_next = S_IDLE;
      case (r_state)
         S_IDLE: w_next = w_start ? S_WAIT : S_IDLE;
         S_WAIT: w_next = w_quit ? S_IDLE : (r_cnt != '0) ? S_WAIT : (BUSY_IN != '0) ? S_HOLD : S_FIRE;
         S_HOLD: w_next = w_quit ? S_IDLE : (BUSY_IN != '0) ? S_HOLD : S_FIRE;
         // a quit seen during FIRE only takes effect once the full high time is out
         S_FIRE: w_next = !w_last ? S_FIRE : (r_quit || w_quit || w_bend) ? S_IDLE : S_WAIT;
         default: w_next = S_IDLE;
      endcase
   end
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state   <= S_IDLE;
         r_trig    <= 1'b0;
         r_period  <= '0;
         r_cnt     <= '0;
         r_burst   <= '0;
         r_pulses  <= '0;
         r_defer   <= '0;
         r_tcnt    <= '0;
         r_running <= 1'b0;
         r_done    <= 1'b0;
         r_quit    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_trig  <= w_next == S_FIRE;
         r_tcnt  <= (r_state == S_FIRE) ? r_tcnt + TCW'(1) : '0;
         r_quit  <= (r_state == S_FIRE) && (w_next == S_FIRE) && (r_quit || w_quit);
         if (WR_PERIOD)
            r_period <= DIN[PERIOD_W-1:0];
         if (w_next == S_WAIT)
            r_cnt <= (r_state == S_WAIT) ? r_cnt - PERIOD_W'(1) : w_reload;
         if (r_state == S_IDLE && w_start) begin
            r_burst   <= DIN[16 +: CNT_W];
            r_pulses  <= '0;
            r_defer   <= '0;
            r_done    <= 1'b0;
            r_running <= 1'b1;
         end
         if (w_next == S_FIRE && r_state != S_FIRE)
            r_pulses <= r_pulses + CNT_W'(1);
         if (w_next == S_HOLD && r_state == S_WAIT && r_defer != 8'hff)
            r_defer <= r_defer + 8'd1;
         if (w_next == S_IDLE && r_state != S_IDLE) begin
            r_running <= 1'b0;
            r_done    <= (r_state == S_FIRE) && w_bend && !r_quit && !w_quit;
         end
      end
   end
   assign TRIG_OUT = r_trig;
   assign DO = {2'b00, r_done, r_running, r_state, r_defer, 16'(r_pulses)};
endmodule
